// File: rtl/cdb_arbiter_pkg.sv
// Core sizing shared by the CDB arbiter and the ROB: ROB depth, tag and data
// widths, and the number of CDB broadcast slots.
package cdb_arbiter_pkg;

   localparam int ROB_DEPTH     = 16;
   localparam int ROB_TAG_W     = $clog2(ROB_DEPTH);
   localparam int CDB_DATA_W    = 16;
   localparam int CDB_NUM_SLOTS = 4;   // one per ROB completion port
   localparam int CDB_NUM_REQ   = 6;   // functional units competing for the CDB

   // Width of an index into n items; never less than one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_multi_grant.sv
// rr_multi_grant: purely combinational circular scan starting at rr_ptr.
// Grants up to CDB_SLOTS valid requesters and compacts them, in scan order,
// into slots 0..k-1. Unused slots are all-zero. next_ptr is one past the last
// granted requester (mod NUM_REQ), or rr_ptr when nothing is granted.
module rr_multi_grant
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = CDB_NUM_REQ,
   parameter int CDB_SLOTS = CDB_NUM_SLOTS,
   parameter int TAG_W     = ROB_TAG_W,
   parameter int DATA_W    = CDB_DATA_W,
   parameter int PTR_W     = idx_w(NUM_REQ)
) (
   input  logic [PTR_W-1:0]                  rr_ptr,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tags,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_values,
   output logic [NUM_REQ-1:0]                grant,
   output logic [CDB_SLOTS-1:0]              slot_valid,
   output logic [CDB_SLOTS-1:0][TAG_W-1:0]   slot_tags,
   output logic [CDB_SLOTS-1:0][DATA_W-1:0]  slot_values,
   output logic [PTR_W-1:0]                  next_ptr
);

   localparam int CNT_W  = $clog2(CDB_SLOTS + 1);
   localparam int SLOT_W = idx_w(CDB_SLOTS);

   // Walk requesters rr_ptr, rr_ptr+1, ... and fill slots until they run out
   always_comb begin : scan
      logic [PTR_W:0]   pos;
      logic [PTR_W-1:0] idx;
      logic [CNT_W-1:0] cnt;
      grant       = '0;
      slot_valid  = '0;
      slot_tags   = '0;
      slot_values = '0;
      next_ptr    = rr_ptr;
      pos         = '0;
      idx         = '0;
      cnt         = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         // rr_ptr + j < 2*NUM_REQ, so one conditional subtract gives the modulo
         pos = {1'b0, rr_ptr} + (PTR_W+1)'(j);
         if (pos >= (PTR_W+1)'(NUM_REQ))
            pos = pos - (PTR_W+1)'(NUM_REQ);
         idx = pos[PTR_W-1:0];
         if (req_valid[idx] && (cnt < CNT_W'(CDB_SLOTS))) begin
            grant[idx]                      = 1'b1;
            slot_valid[cnt[SLOT_W-1:0]]     = 1'b1;
            slot_tags[cnt[SLOT_W-1:0]]      = req_tags[idx];
            slot_values[cnt[SLOT_W-1:0]]    = req_values[idx];
            cnt                             = cnt + 1'b1;
            next_ptr = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin multi-grant arbiter driving the common data bus.
// Up to CDB_SLOTS results are granted per cycle and broadcast, registered,
// on the following cycle. flush drops grants and clears the bus without
// moving the round-robin pointer.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = CDB_NUM_REQ,
   parameter int CDB_SLOTS = CDB_NUM_SLOTS,
   parameter int TAG_W     = ROB_TAG_W,
   parameter int DATA_W    = CDB_DATA_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic [NUM_REQ-1:0]            req_valid_flat,
   input  logic [NUM_REQ*TAG_W-1:0]      req_tags_flat,
   input  logic [NUM_REQ*DATA_W-1:0]     req_values_flat,
   output logic [NUM_REQ-1:0]            req_ready_flat,
   output logic [CDB_SLOTS-1:0]          cdb_valid_flat,
   output logic [CDB_SLOTS*TAG_W-1:0]    cdb_indices_flat,
   output logic [CDB_SLOTS*DATA_W-1:0]   cdb_values_flat
);

   localparam int PTR_W = idx_w(NUM_REQ);

   logic [PTR_W-1:0]                  rr_ptr;
   logic [PTR_W-1:0]                  next_ptr;
   logic [NUM_REQ-1:0]                req_valid;
   logic [NUM_REQ-1:0][TAG_W-1:0]     req_tags;
   logic [NUM_REQ-1:0][DATA_W-1:0]    req_values;
   logic [NUM_REQ-1:0]                grant;
   logic [CDB_SLOTS-1:0]              slot_valid;
   logic [CDB_SLOTS-1:0][TAG_W-1:0]   slot_tags;
   logic [CDB_SLOTS-1:0][DATA_W-1:0]  slot_values;
   logic [CDB_SLOTS-1:0]              cdb_valid;
   logic [CDB_SLOTS-1:0][TAG_W-1:0]   cdb_idx;
   logic [CDB_SLOTS-1:0][DATA_W-1:0]  cdb_val;

   // Flat ports are MSB-first: requester i lives at position NUM_REQ-1-i
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign req_valid[i]  = req_valid_flat[NUM_REQ-1-i];
      assign req_tags[i]   = req_tags_flat[(NUM_REQ-1-i)*TAG_W +: TAG_W];
      assign req_values[i] = req_values_flat[(NUM_REQ-1-i)*DATA_W +: DATA_W];
      // Ready is blocked by flush and by reset so no transfer is seen then
      assign req_ready_flat[NUM_REQ-1-i] = grant[i] & ~flush & rst_n;
   end

   // Slot s lives at position CDB_SLOTS-1-s
   for (genvar s = 0; s < CDB_SLOTS; s++) begin : g_slot
      assign cdb_valid_flat[CDB_SLOTS-1-s]                     = cdb_valid[s];
      assign cdb_indices_flat[(CDB_SLOTS-1-s)*TAG_W +: TAG_W]  = cdb_idx[s];
      assign cdb_values_flat[(CDB_SLOTS-1-s)*DATA_W +: DATA_W] = cdb_val[s];
   end

   rr_multi_grant #(
      .NUM_REQ   (NUM_REQ),
      .CDB_SLOTS (CDB_SLOTS),
      .TAG_W     (TAG_W),
      .DATA_W    (DATA_W),
      .PTR_W     (PTR_W)
   ) u_grant (
      .rr_ptr      (rr_ptr),
      .req_valid   (req_valid),
      .req_tags    (req_tags),
      .req_values  (req_values),
      .grant       (grant),
      .slot_valid  (slot_valid),
      .slot_tags   (slot_tags),
      .slot_values (slot_values),
      .next_ptr    (next_ptr)
   );

   // Register the compacted slots onto the bus and advance the pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         cdb_valid <= '0;
         cdb_idx   <= '0;
         cdb_val   <= '0;
      end else if (flush) begin
         cdb_valid <= '0;
         cdb_idx   <= '0;
         cdb_val   <= '0;
      end else begin
         rr_ptr    <= next_ptr;
         cdb_valid <= slot_valid;
         cdb_idx   <= slot_tags;
         cdb_val   <= slot_values;
      end
   end

   // Two live slots with one ROB index means an upstream unit reissued a tag
   always @(posedge clk) begin
      if (rst_n) begin
         for (int s = 0; s < CDB_SLOTS; s++) begin
            for (int t = s + 1; t < CDB_SLOTS; t++) begin
               assert (!(cdb_valid[s] && cdb_valid[t] && (cdb_idx[s] == cdb_idx[t])))
                  else $error("cdb_arbiter: tag %0d on slots %0d and %0d", cdb_idx[s], s, t);
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed cases plus a random stress run. Each cycle
// the expected broadcast is pushed to a queue and compared one cycle later.
module tb_cdb_arbiter;

   localparam int NR = 6;
   localparam int NS = 4;
   localparam int TW = 4;
   localparam int DW = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic [NR-1:0]    req_valid_flat = '0;
   logic [NR*TW-1:0] req_tags_flat = '0;
   logic [NR*DW-1:0] req_values_flat = '0;
   logic [NR-1:0]    req_ready_flat;
   logic [NS-1:0]    cdb_valid_flat;
   logic [NS*TW-1:0] cdb_indices_flat;
   logic [NS*DW-1:0] cdb_values_flat;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(NR), .CDB_SLOTS(NS), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flush            (flush),
      .req_valid_flat   (req_valid_flat),
      .req_tags_flat    (req_tags_flat),
      .req_values_flat  (req_values_flat),
      .req_ready_flat   (req_ready_flat),
      .cdb_valid_flat   (cdb_valid_flat),
      .cdb_indices_flat (cdb_indices_flat),
      .cdb_values_flat  (cdb_values_flat)
   );

   typedef struct packed {
      logic [NS-1:0]    v;
      logic [NS*TW-1:0] t;
      logic [NS*DW-1:0] d;
   } exp_t;

   exp_t          sbq[$];
   logic [NR-1:0] rv = '0;          // bit i = requester i
   logic [NR-1:0] last_g = '0;
   logic [NR-1:0] last_ready = '0;
   logic [NR-1:0] tog = '0;
   logic [TW-1:0] tg[NR];
   logic [DW-1:0] vl[NR];
   int            age[NR];
   int            m_rr = 0;
   int            n_vec = 0;
   int            n_err = 0;
   bit            stress = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid_flat[NR-1-i]               = rv[i];
         req_tags_flat[(NR-1-i)*TW +: TW]     = tg[i];
         req_values_flat[(NR-1-i)*DW +: DW]   = vl[i];
      end
   endtask

   task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
      rv[i] = 1'b1;
      tg[i] = t;
      vl[i] = d;
   endtask

   task automatic drop_granted();
      for (int i = 0; i < NR; i++) if (last_g[i]) rv[i] = 1'b0;
   endtask

   // Reference: circular scan from m_rr, first NS valid requesters
   task automatic model(output logic [NR-1:0] g, output exp_t e, output int nrr);
      int k;
      int i;
      k = 0;
      g = '0;
      e = '0;
      nrr = m_rr;
      if (!flush) begin
         for (int j = 0; j < NR; j++) begin
            i = (m_rr + j) % NR;
            if (rv[i] && k < NS) begin
               g[i] = 1'b1;
               e.v[NS-1-k] = 1'b1;
               e.t[(NS-1-k)*TW +: TW] = tg[i];
               e.d[(NS-1-k)*DW +: DW] = vl[i];
               k++;
               nrr = (i + 1) % NR;
            end
         end
      end
   endtask

   // Called at a negedge: drive, check ready, then check the broadcast next cycle
   task automatic cycle();
      logic [NR-1:0] g;
      logic [NR-1:0] er;
      exp_t e;
      exp_t o;
      int nrr;
      drive();
      #2;
      model(g, e, nrr);
      er = '0;
      for (int i = 0; i < NR; i++) er[NR-1-i] = g[i];
      last_ready = req_ready_flat;
      chk("ready", 64'(req_ready_flat), 64'(er));
      for (int i = 0; i < NR; i++) begin
         if (rv[i]) begin
            age[i]++;
            if (g[i]) begin
               if (stress) chk("wait_bound", 64'(age[i] <= 2), 64'd1);
               age[i] = 0;
            end
         end
      end
      last_g = g;
      sbq.push_back(e);
      @(posedge clk);
      m_rr = nrr;
      @(negedge clk);
      o = sbq.pop_front();
      chk("cdb_valid", 64'(cdb_valid_flat), 64'(o.v));
      chk("cdb_idx", 64'(cdb_indices_flat), 64'(o.t));
      chk("cdb_val", 64'(cdb_values_flat), 64'(o.d));
      chk("rr_ptr", 64'(dut.rr_ptr), 64'(m_rr));
   endtask

   // Holds reset for two cycles with whatever requests are pending, then releases
   task automatic do_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      drive();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", 64'(req_ready_flat), 64'd0);
      chk("rst_valid", 64'(cdb_valid_flat), 64'd0);
      chk("rst_idx", 64'(cdb_indices_flat), 64'd0);
      chk("rst_val", 64'(cdb_values_flat), 64'd0);
      chk("rst_rr", 64'(dut.rr_ptr), 64'd0);
      sbq.delete();
      m_rr = 0;
      for (int i = 0; i < NR; i++) age[i] = 0;
      @(negedge clk);
      rv = '0;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         tg[i] = '0;
         vl[i] = '0;
         age[i] = 0;
      end

      // Reset with every requester asserting valid
      for (int i = 0; i < NR; i++) set_req(i, TW'(i), DW'(i));
      do_reset();

      // Single request; then an idle cycle shows the pulse is one cycle long
      set_req(2, 4'd5, 16'h00AB);
      cycle();
      chk("single_ready", 64'(last_ready), 64'b001000);
      chk("single_v", 64'(cdb_valid_flat), 64'b1000);
      chk("single_idx", 64'(cdb_indices_flat), 64'h5000);
      chk("single_val", 64'(cdb_values_flat), 64'h00AB_0000_0000_0000);
      chk("single_rr", 64'(dut.rr_ptr), 64'd3);
      drop_granted();
      cycle();

      // Oversubscription: all six valid from rr_ptr=0
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, TW'(i + 1), DW'(16'h100 * (i + 1)));
      cycle();
      chk("over_ready0", 64'(last_ready), 64'b111100);
      chk("over_rr0", 64'(dut.rr_ptr), 64'd4);
      drop_granted();
      cycle();
      chk("over_ready1", 64'(last_ready), 64'b000011);
      chk("over_v1", 64'(cdb_valid_flat), 64'b1100);
      chk("over_idx1", 64'(cdb_indices_flat), 64'h5600);
      chk("over_rr1", 64'(dut.rr_ptr), 64'd0);
      drop_granted();

      // Wrap from rr_ptr=5 through 0 and 1
      do_reset();
      set_req(4, 4'hA, 16'h1234);
      cycle();
      drop_granted();
      set_req(5, 4'd1, 16'h5555);
      set_req(0, 4'd2, 16'h1000);
      set_req(1, 4'd3, 16'h2000);
      cycle();
      chk("wrap_v", 64'(cdb_valid_flat), 64'b1110);
      chk("wrap_idx", 64'(cdb_indices_flat), 64'h1230);
      chk("wrap_val", 64'(cdb_values_flat), 64'h5555_1000_2000_0000);
      chk("wrap_rr", 64'(dut.rr_ptr), 64'd2);
      drop_granted();

      // Flush with three requests pending, pointer parked at 2
      do_reset();
      set_req(1, 4'd7, 16'hBEEF);
      cycle();
      drop_granted();
      set_req(2, 4'd8, 16'h0222);
      set_req(3, 4'd9, 16'h0333);
      set_req(4, 4'd10, 16'h0444);
      flush = 1'b1;
      cycle();
      chk("flush_ready", 64'(last_ready), 64'd0);
      chk("flush_v", 64'(cdb_valid_flat), 64'd0);
      chk("flush_rr", 64'(dut.rr_ptr), 64'd2);
      flush = 1'b0;
      cycle();
      chk("post_flush_v", 64'(cdb_valid_flat), 64'b1110);
      drop_granted();

      // Reset between edges right after a grant lands on the bus
      do_reset();
      set_req(3, 4'd9, 16'hCAFE);
      drive();
      @(posedge clk);
      #2;
      chk("mid_pre_v", 64'(cdb_valid_flat), 64'b1000);
      rst_n = 1'b0;
      #1;
      chk("mid_drop_v", 64'(cdb_valid_flat), 64'd0);
      chk("mid_drop_ready", 64'(req_ready_flat), 64'd0);
      do_reset();
      cycle();
      cycle();

      // Random stress: held requests, unique tags per requester
      do_reset();
      stress = 1'b1;
      last_g = '0;
      for (int c = 0; c < 10000; c++) begin
         drop_granted();
         for (int i = 0; i < NR; i++) begin
            if (!rv[i] && ($urandom_range(0, 1) == 1)) begin
               tog[i] = ~tog[i];
               set_req(i, TW'(2 * i + int'(tog[i])), DW'($urandom));
            end
         end
         cycle();
      end
      drop_granted();
      stress = 1'b0;
      rv = '0;
      cycle();
      cycle();
      chk("sbq_empty", 64'(sbq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 6: number of functional-unit result requesters.
REQ-002 SHALL have parameter CDB_SLOTS, default 4: CDB broadcast slots per cycle, matching the ROB's four completion ports.
REQ-003 SHALL have parameter TAG_W, default 4: ROB index width, for a 16-entry ROB.
REQ-004 SHALL have parameter DATA_W, default 16: result value width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port flush, input, 1 bit: discards all pending broadcasts.
REQ-008 SHALL have port req_valid_flat, input, NUM_REQ bits: requester i holds a result; requester i sits at bit NUM_REQ-1-i.
REQ-009 SHALL have port req_tags_flat, input, NUM_REQ*TAG_W bits: ROB index per requester, same MSB-first packing.
REQ-010 SHALL have port req_values_flat, input, NUM_REQ*DATA_W bits: result value per requester, same packing.
REQ-011 SHALL have port req_ready_flat, output, NUM_REQ bits: requester i is granted this cycle; same packing.
REQ-012 SHALL have port cdb_valid_flat, output, CDB_SLOTS bits: slot valid; slot s sits at bit CDB_SLOTS-1-s.
REQ-013 SHALL have port cdb_indices_flat, output, CDB_SLOTS*TAG_W bits: ROB index per slot, same packing.
REQ-014 SHALL have port cdb_values_flat, output, CDB_SLOTS*DATA_W bits: value per slot, same packing.

Function
REQ-015 SHALL provide a round-robin pointer rr_ptr, range 0..NUM_REQ-1, that marks the highest-priority requester.
REQ-016 SHALL scan requesters combinationally in circular order rr_ptr, rr_ptr+1, ... mod NUM_REQ, and grant the first min(CDB_SLOTS, number valid) valid ones.
REQ-017 SHALL drive req_ready high only for granted requesters; ready SHALL NOT depend on req_ready.
REQ-018 SHALL treat a transfer as valid&ready in the same cycle; a requester SHALL hold its valid, tag and value stable until it is granted.
REQ-019 SHALL pack granted results into slots 0..k-1 in scan order, with no holes; slots k..CDB_SLOTS-1 SHALL carry valid=0, and their index and value SHALL be zero.
REQ-020 SHALL register the cdb_* outputs: a result granted in cycle N SHALL appear on the CDB in cycle N+1 only, with a one-cycle valid pulse.
REQ-021 SHALL, when k>0, set rr_ptr to (index of the last granted requester + 1) mod NUM_REQ; when k=0, rr_ptr SHALL be unchanged.
REQ-022 SHALL guarantee fairness: a continuously valid requester SHALL be granted within ceil(NUM_REQ/CDB_SLOTS) cycles (2 at the defaults).
REQ-023 SHALL, while flush=1, force all req_ready=0, clear cdb_valid on the next edge and leave rr_ptr unchanged; flush SHALL take priority over grants in the same cycle.
REQ-024 SHALL compute pointer arithmetic modulo NUM_REQ for any NUM_REQ; wrap-around from NUM_REQ-1 to 0 SHALL be seamless.
REQ-025 SHALL pass tags through unmodified; two slots carrying the same tag in one cycle is an upstream error, flagged by a simulation-only assertion.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously set rr_ptr=0, cdb_valid_flat=0, cdb_indices_flat=0 and cdb_values_flat=0.
REQ-027 SHALL drive req_ready_flat=0 while rst_n=0.
REQ-028 SHALL discard any grant in flight when reset asserts mid-operation; nothing SHALL be broadcast after reset releases.
REQ-029 SHALL allow the first grant on the first posedge after rst_n rises.

Structure
REQ-030 SHALL place TAG_W, DATA_W, CDB_SLOTS and the ROB depth (16) in the shared core package, which the ROB also uses.
REQ-031 SHALL implement the circular scan-and-compact logic as one sub-module, rr_multi_grant, that is purely combinational; rr_ptr and the output registers SHALL stay in cdb_arbiter.

Verification
REQ-032 SHALL cover single request: req 2 valid with tag 5 and value 0x00AB, rr_ptr=0 -> ready2=1; next cycle slot0 valid=1, index=5, value 0x00AB, slots 1-3 invalid; rr_ptr becomes 3.
REQ-033 SHALL cover oversubscription: all 6 valid at rr_ptr=0 -> reqs 0-3 granted, rr_ptr becomes 4; next cycle reqs 4 and 5 are granted first and fill slots 0 and 1.
REQ-034 SHALL cover wrap: rr_ptr=5 with reqs 5, 0 and 1 valid -> slots 0-2 carry reqs 5, 0, 1 in that order; rr_ptr becomes 2.
REQ-035 SHALL cover flush: flush=1 with 3 requests valid -> all ready=0; next cycle cdb_valid=0 and rr_ptr unchanged.
REQ-036 SHALL cover reset mid-grant: assert rst_n=0 between edges after a grant -> cdb_valid drops immediately, with no broadcast after release.
REQ-037 SHALL cover random stress: 10k cycles of random valid with held values -> every request is broadcast exactly once, waits at most 2 cycles after becoming eligible, and is checked against a scoreboard.
